// File: rtl/reg_arbiter.sv
// Round-robin arbiter sharing one register-bus master port among NUM_REQ requesters.
// Forwards one transaction at a time and forces completion after TIMEOUT cycles without ack.
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module reg_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned REG_ADDR_BITS = 23,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_REQ-1:0]                       req_in,
    input  logic [NUM_REQ-1:0]                       rd_wr_L_in,
    input  logic [NUM_REQ*REG_ADDR_BITS-1:0]         addr_in,
    input  logic [NUM_REQ*`CPCI_NF2_DATA_WIDTH-1:0]  wr_data_in,
    output logic [NUM_REQ-1:0]                       ack_out,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]          rd_data_out,
    output logic                                     reg_req,
    output logic                                     reg_rd_wr_L,
    output logic [REG_ADDR_BITS-1:0]                 reg_addr,
    output logic [`CPCI_NF2_DATA_WIDTH-1:0]          reg_wr_data,
    input  logic                                     reg_ack,
    input  logic [`CPCI_NF2_DATA_WIDTH-1:0]          reg_rd_data,
    output logic                                     timeout_evt
);

    localparam int unsigned DW = `CPCI_NF2_DATA_WIDTH;
    localparam int unsigned GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StDrain
    } state_e;

    state_e          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   last_grant_q;
    logic [TW-1:0]   timer_q;

    logic [REG_ADDR_BITS-1:0] addr_arr [NUM_REQ];
    logic [DW-1:0]            wdat_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = addr_in[g*REG_ADDR_BITS +: REG_ADDR_BITS];
        assign wdat_arr[g] = wr_data_in[g*DW +: DW];
    end

    // Scan from the requester after the last winner, wrapping around.
    int            cand;
    logic [GW-1:0] cand_idx;
    logic [GW-1:0] win_idx;
    logic          found;

    always_comb begin
        cand     = 0;
        cand_idx = '0;
        win_idx  = '0;
        found    = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand     = (int'(last_grant_q) + 1 + i) % int'(NUM_REQ);
            cand_idx = GW'(cand);
            if (!found && req_in[cand_idx]) begin
                found   = 1'b1;
                win_idx = cand_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            timer_q      <= '0;
            ack_out      <= '0;
            rd_data_out  <= '0;
            reg_req      <= 1'b0;
            reg_rd_wr_L  <= 1'b0;
            reg_addr     <= '0;
            reg_wr_data  <= '0;
            timeout_evt  <= 1'b0;
        end else begin
            ack_out     <= '0;
            timeout_evt <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|req_in) begin
                        grant_q      <= win_idx;
                        last_grant_q <= win_idx;
                        reg_rd_wr_L  <= rd_wr_L_in[win_idx];
                        reg_addr     <= addr_arr[win_idx];
                        reg_wr_data  <= wdat_arr[win_idx];
                        reg_req      <= 1'b1;
                        timer_q      <= '0;
                        state_q      <= StActive;
                    end
                end
                StActive: begin
                    // A real ack wins over a timeout falling on the same edge.
                    if (reg_ack) begin
                        rd_data_out <= reg_rd_data;
                        ack_out     <= NUM_REQ'(1) << grant_q;
                        reg_req     <= 1'b0;
                        state_q     <= StDrain;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        rd_data_out <= DW'(32'hdead_beef);
                        ack_out     <= NUM_REQ'(1) << grant_q;
                        timeout_evt <= 1'b1;
                        reg_req     <= 1'b0;
                        state_q     <= StDrain;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                StDrain: begin
                    if (!reg_ack && !req_in[grant_q]) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && state_q == StIdle && reg_ack === 1'b1) begin
            $display("ERROR: reg_arbiter: reg_ack high while idle at %0t", $time);
        end
    end
`endif

endmodule

// File: tb/tb_reg_arbiter.sv
// Self-checking bench for reg_arbiter: scoreboard of expected completions plus
// per-scenario timing checks on the downstream request side.
`ifndef CPCI_NF2_DATA_WIDTH
`define CPCI_NF2_DATA_WIDTH 32
`endif

module tb_reg_arbiter;

    localparam int NR = 2;
    localparam int AB = 23;
    localparam int DW = `CPCI_NF2_DATA_WIDTH;
    localparam int TO = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_in = '0;
    logic [NR-1:0]     rd_wr_L_in = '0;
    logic [NR*AB-1:0]  addr_in = '0;
    logic [NR*DW-1:0]  wr_data_in = '0;
    logic [NR-1:0]     ack_out;
    logic [DW-1:0]     rd_data_out;
    logic              reg_req;
    logic              reg_rd_wr_L;
    logic [AB-1:0]     reg_addr;
    logic [DW-1:0]     reg_wr_data;
    logic              reg_ack = 1'b0;
    logic [DW-1:0]     reg_rd_data = '0;
    logic              timeout_evt;

    reg_arbiter #(
        .NUM_REQ       (NR),
        .REG_ADDR_BITS (AB),
        .TIMEOUT       (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_in      (req_in),
        .rd_wr_L_in  (rd_wr_L_in),
        .addr_in     (addr_in),
        .wr_data_in  (wr_data_in),
        .ack_out     (ack_out),
        .rd_data_out (rd_data_out),
        .reg_req     (reg_req),
        .reg_rd_wr_L (reg_rd_wr_L),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .reg_ack     (reg_ack),
        .reg_rd_data (reg_rd_data),
        .timeout_evt (timeout_evt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NR-1:0] ack;
        logic [DW-1:0] data;
        logic          tevt;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   model_last = NR - 1;

    // Completion monitor: every ack_out pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && ack_out != '0) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_unexpected_ack: got ack_out=%b, required no completion", ack_out);
            end else begin
                mon_e = sb_q.pop_front();
                if (ack_out !== mon_e.ack || rd_data_out !== mon_e.data ||
                    timeout_evt !== mon_e.tevt) begin
                    n_err++;
                    $display("FAIL sb_completion: got ack=%b data=%h tevt=%b, required ack=%b data=%h tevt=%b",
                             ack_out, rd_data_out, timeout_evt, mon_e.ack, mon_e.data, mon_e.tevt);
                end
            end
        end else if (!reset && timeout_evt !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_stray_timeout: got timeout_evt=%b without ack, required 0", timeout_evt);
        end
    end

    task automatic set_txn(input int j, input logic rd, input logic [AB-1:0] a,
                           input logic [DW-1:0] d);
        rd_wr_L_in[j]         = rd;
        addr_in[j*AB +: AB]   = a;
        wr_data_in[j*DW +: DW] = d;
    endtask

    task automatic wait_reg_req(input int budget, output int cycles);
        cycles = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (reg_req === 1'b1) begin
                cycles = i + 1;
                break;
            end
        end
    endtask

    task automatic wait_ack(input int j, input int budget, output int cycles);
        cycles = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack_out[j] === 1'b1) begin
                cycles = i + 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (reg_req !== 1'b0) begin n_err++; $display("FAIL reset_reg_req: got %b, required 0", reg_req); end
        n_cmp++; if (ack_out !== '0) begin n_err++; $display("FAIL reset_ack_out: got %b, required 00", ack_out); end
        n_cmp++; if (timeout_evt !== 1'b0) begin n_err++; $display("FAIL reset_timeout_evt: got %b, required 0", timeout_evt); end
        n_cmp++; if (rd_data_out !== '0 || reg_addr !== '0 || reg_wr_data !== '0 || reg_rd_wr_L !== 1'b0) begin
            n_err++;
            $display("FAIL reset_fields: got rd=%h addr=%h wd=%h rw=%b, required all 0",
                     rd_data_out, reg_addr, reg_wr_data, reg_rd_wr_L);
        end
        model_last = NR - 1;
    endtask

    task automatic test_read;
        @(negedge clk);
        set_txn(0, 1'b1, 23'h000010, '0);
        req_in[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if (reg_req !== 1'b1) begin n_err++; $display("FAIL read_req_latency: got reg_req=%b, required 1", reg_req); end
        n_cmp++; if (reg_addr !== 23'h000010 || reg_rd_wr_L !== 1'b1) begin
            n_err++; $display("FAIL read_fields: got addr=%h rw=%b, required addr=000010 rw=1", reg_addr, reg_rd_wr_L);
        end
        model_last = 0;
        repeat (3) @(negedge clk);
        sb_q.push_back('{ack: 2'b01, data: 32'h12345678, tevt: 1'b0});
        reg_ack = 1'b1;
        reg_rd_data = 32'h12345678;
        @(negedge clk);
        n_cmp++; if (ack_out !== 2'b01 || reg_req !== 1'b0) begin
            n_err++; $display("FAIL read_ack: got ack=%b reg_req=%b, required ack=01 reg_req=0", ack_out, reg_req);
        end
        reg_ack = 1'b0;
        req_in[0] = 1'b0;
        @(negedge clk);
        n_cmp++; if (ack_out !== 2'b00 || rd_data_out !== 32'h12345678) begin
            n_err++; $display("FAIL read_ack_width: got ack=%b rd=%h, required ack=00 rd=12345678", ack_out, rd_data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        int exp_j;
        int cyc;
        logic [AB-1:0] exp_a;
        set_txn(0, 1'b1, 23'h000100, '0);
        set_txn(1, 1'b1, 23'h000200, '0);
        @(negedge clk);
        req_in = 2'b11;
        for (int k = 0; k < 5; k++) begin
            exp_j = (model_last + 1) % NR;
            exp_a = (exp_j == 0) ? 23'h000100 : 23'h000200;
            wait_reg_req(20, cyc);
            n_cmp++; if (cyc < 0 || reg_addr !== exp_a) begin
                n_err++; $display("FAIL rr_grant_%0d: got reg_req wait=%0d addr=%h, required addr=%h",
                                  k, cyc, reg_addr, exp_a);
            end
            model_last = exp_j;
            sb_q.push_back('{ack: NR'(1) << exp_j, data: 32'ha0000000 + k, tevt: 1'b0});
            reg_ack = 1'b1;
            reg_rd_data = 32'ha0000000 + k;
            wait_ack(exp_j, 5, cyc);
            n_cmp++; if (cyc != 1) begin
                n_err++; $display("FAIL rr_ack_%0d: got ack after %0d cycles, required 1", k, cyc);
            end
            reg_ack = 1'b0;
            req_in[exp_j] = 1'b0;
            @(negedge clk);
            if (k < 3) req_in[exp_j] = 1'b1;
        end
        req_in = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout;
        int cnt;
        @(negedge clk);
        set_txn(1, 1'b0, 23'h000300, 32'h5555aaaa);
        sb_q.push_back('{ack: 2'b10, data: 32'hdeadbeef, tevt: 1'b1});
        req_in[1] = 1'b1;
        @(negedge clk);
        n_cmp++; if (reg_req !== 1'b1 || reg_rd_wr_L !== 1'b0 || reg_wr_data !== 32'h5555aaaa) begin
            n_err++; $display("FAIL to_issue: got req=%b rw=%b wd=%h, required req=1 rw=0 wd=5555aaaa",
                              reg_req, reg_rd_wr_L, reg_wr_data);
        end
        model_last = 1;
        cnt = -1;
        for (int i = 1; i <= TO + 3; i++) begin
            @(negedge clk);
            if (ack_out[1] === 1'b1) begin
                cnt = i;
                break;
            end
        end
        n_cmp++; if (cnt != TO) begin
            n_err++; $display("FAIL to_latency: got ack after %0d cycles, required %0d", cnt, TO);
        end
        n_cmp++; if (reg_req !== 1'b0 || timeout_evt !== 1'b1) begin
            n_err++; $display("FAIL to_edge: got reg_req=%b tevt=%b, required reg_req=0 tevt=1", reg_req, timeout_evt);
        end
        req_in[1] = 1'b0;
        @(negedge clk);
        n_cmp++; if (timeout_evt !== 1'b0 || rd_data_out !== 32'hdeadbeef) begin
            n_err++; $display("FAIL to_after: got tevt=%b rd=%h, required tevt=0 rd=deadbeef", timeout_evt, rd_data_out);
        end
        @(negedge clk);
    endtask

    task automatic test_ack_at_limit;
        @(negedge clk);
        set_txn(0, 1'b1, 23'h000400, '0);
        req_in[0] = 1'b1;
        @(negedge clk);
        model_last = 0;
        repeat (TO - 1) @(negedge clk);
        sb_q.push_back('{ack: 2'b01, data: 32'hcafef00d, tevt: 1'b0});
        reg_ack = 1'b1;
        reg_rd_data = 32'hcafef00d;
        @(negedge clk);
        n_cmp++; if (ack_out !== 2'b01 || timeout_evt !== 1'b0 || rd_data_out !== 32'hcafef00d) begin
            n_err++; $display("FAIL limit_ack_wins: got ack=%b tevt=%b rd=%h, required ack=01 tevt=0 rd=cafef00d",
                              ack_out, timeout_evt, rd_data_out);
        end
        reg_ack = 1'b0;
        req_in[0] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ack_hold;
        int cyc;
        set_txn(0, 1'b1, 23'h000500, '0);
        set_txn(1, 1'b1, 23'h000600, '0);
        @(negedge clk);
        req_in[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if (reg_req !== 1'b1 || reg_addr !== 23'h000500) begin
            n_err++; $display("FAIL hold_first: got req=%b addr=%h, required req=1 addr=000500", reg_req, reg_addr);
        end
        model_last = 0;
        req_in[1] = 1'b1;
        sb_q.push_back('{ack: 2'b01, data: 32'h11111111, tevt: 1'b0});
        reg_ack = 1'b1;
        reg_rd_data = 32'h11111111;
        @(negedge clk);
        req_in[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (reg_req !== 1'b0) begin
                n_err++; $display("FAIL hold_no_req_%0d: got reg_req=%b while reg_ack high, required 0", i, reg_req);
            end
        end
        reg_ack = 1'b0;
        wait_reg_req(10, cyc);
        n_cmp++; if (cyc != 2 || reg_addr !== 23'h000600) begin
            n_err++; $display("FAIL hold_second: got wait=%0d addr=%h, required wait=2 addr=000600", cyc, reg_addr);
        end
        model_last = 1;
        sb_q.push_back('{ack: 2'b10, data: 32'h22222222, tevt: 1'b0});
        reg_ack = 1'b1;
        reg_rd_data = 32'h22222222;
        wait_ack(1, 5, cyc);
        reg_ack = 1'b0;
        req_in[1] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        set_txn(0, 1'b1, 23'h000700, '0);
        set_txn(1, 1'b1, 23'h000800, '0);
        @(negedge clk);
        req_in[0] = 1'b1;
        @(negedge clk);
        n_cmp++; if (reg_req !== 1'b1) begin n_err++; $display("FAIL rst_mid_active: got reg_req=%b, required 1", reg_req); end
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (reg_req !== 1'b0 || ack_out !== 2'b00 || timeout_evt !== 1'b0) begin
            n_err++; $display("FAIL rst_async_outputs: got req=%b ack=%b tevt=%b, required 0/00/0",
                              reg_req, ack_out, timeout_evt);
        end
        n_cmp++; if (rd_data_out !== '0 || reg_addr !== '0) begin
            n_err++; $display("FAIL rst_async_data: got rd=%h addr=%h, required 0", rd_data_out, reg_addr);
        end
        req_in = '0;
        @(negedge clk);
        reset = 1'b0;
        model_last = NR - 1;
        @(negedge clk);
        req_in = 2'b11;
        for (int k = 0; k < 2; k++) begin
            wait_reg_req(10, cyc);
            n_cmp++; if (cyc < 0 || reg_addr !== ((k == 0) ? 23'h000700 : 23'h000800)) begin
                n_err++; $display("FAIL rst_after_grant_%0d: got wait=%0d addr=%h, required requester %0d",
                                  k, cyc, reg_addr, k);
            end
            sb_q.push_back('{ack: NR'(1) << k, data: 32'hb0000000 + k, tevt: 1'b0});
            reg_ack = 1'b1;
            reg_rd_data = 32'hb0000000 + k;
            wait_ack(k, 5, cyc);
            reg_ack = 1'b0;
            req_in[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_timeout();
        test_ack_at_limit();
        test_ack_hold();
        test_reset_mid();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_leftover: got %0d outstanding completions, required 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
